// File: rtl/pll_dphase_ctrl_if.sv
// Request channel for the PLL dynamic phase-shift sequencer.
//   req_valid/req_ready : handshake
//   req_sel/req_dir/req_steps : output select, direction, fine-step count
//   done/abort : single-cycle completion / lock-loss termination pulses
// master = requester, slave = sequencer.
interface pll_dphase_ctrl_if #(
  parameter int unsigned STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;
  logic              done;
  logic              abort;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, done, abort
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, done, abort
  );
endinterface

// File: rtl/pll_dphase_ctrl.sv
// Sequencer for the ECP5 EHXPLLL dynamic phase-shift port.
// Accepts phase-move requests and emits timed active-low PHASESTEP pulses,
// tracks the phase position of all four PLL outputs and gates operation on
// a debounced PLL lock.
//   clkin      : PLL reference clock (sole clock)
//   rstn       : synchronous active-low reset
//   pll_locked : asynchronous PLL LOCK, synchronised internally
//   req        : request channel (slave side)
//   locked_o   : debounced lock
//   pos        : packed positions, output n at [n*POS_W +: POS_W]
//   phasesel/phasedir/phasestep : to the PLL dynamic phase port
module pll_dphase_ctrl #(
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned POS_W     = 7,
  parameter int unsigned PHASE_MOD = 64,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned LOCK_CYC  = 16,
  parameter int unsigned DIR_INV   = 0
) (
  input  logic                 clkin,
  input  logic                 rstn,
  input  logic                 pll_locked,
  pll_dphase_ctrl_if.slave     req,
  output logic                 locked_o,
  output logic [4*POS_W-1:0]   pos,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep
);

  localparam int unsigned MAXC0  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAXC   = (MAXC0 > GAP_CYC) ? MAXC0 : GAP_CYC;
  localparam int unsigned TMR_W  = $clog2(MAXC + 1);
  localparam int unsigned LCNT_W = $clog2(LOCK_CYC + 1);
  localparam logic        DINV   = (DIR_INV != 0);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    SETUP     = 3'd2,
    PULSE     = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              locked_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic [POS_W-1:0]  pos_q [4];
  logic [POS_W-1:0]  pos_d [4];
  logic [POS_W-1:0]  cur_pos, nxt_pos;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [1:0]        phasesel_d;
  logic              phasedir_d, phasestep_d;

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.abort     = abort_q;

  for (genvar i = 0; i < 4; i++) begin : g_pos
    assign pos[i*POS_W +: POS_W] = pos_q[i];
  end

  // Lock synchroniser and saturating debounce counter
  always_comb begin
    sync_d = {sync_q[0], pll_locked};
    if (!sync_q[1])
      lcnt_d = '0;
    else if (lcnt_q != LCNT_W'(LOCK_CYC))
      lcnt_d = lcnt_q + 1'b1;
    else
      lcnt_d = lcnt_q;
    locked_d = (lcnt_d == LCNT_W'(LOCK_CYC));
  end

  // Modular next position of the selected output
  always_comb begin
    cur_pos = pos_q[sel_q];
    if (dir_q)
      nxt_pos = (cur_pos == POS_W'(PHASE_MOD - 1)) ? '0 : cur_pos + 1'b1;
    else
      nxt_pos = (cur_pos == '0) ? POS_W'(PHASE_MOD - 1) : cur_pos - 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_o) state_d = IDLE;
      end
      IDLE: begin
        if (!locked_o) begin
          state_d = WAIT_LOCK;
        end else if (req.req_valid && ready_q) begin
          sel_d = req.req_sel;
          dir_d = req.req_dir;
          rem_d = req.req_steps;
          if (req.req_steps == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            tmr_d   = TMR_W'(SETUP_CYC - 1);
          end
        end
      end
      SETUP, PULSE, GAP: begin
        if (!locked_o) begin
          // Lock loss: drop the step in flight and any remaining steps
          state_d = WAIT_LOCK;
          abort_d = 1'b1;
          rem_d   = '0;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (state_q == SETUP) begin
          state_d = PULSE;
          tmr_d   = TMR_W'(PULSE_CYC - 1);
        end else if (state_q == PULSE) begin
          // Step completes as phasestep returns high
          state_d        = GAP;
          tmr_d          = TMR_W'(GAP_CYC - 1);
          rem_d          = rem_q - 1'b1;
          pos_d[sel_q]   = nxt_pos;
        end else if (rem_q != '0) begin
          state_d = PULSE;
          tmr_d   = TMR_W'(PULSE_CYC - 1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    ready_d     = (state_d == IDLE) && locked_d;
    phasestep_d = (state_d != PULSE);
    phasesel_d  = phasesel;
    phasedir_d  = phasedir;
    if (state_d == SETUP) begin
      phasesel_d = sel_d;
      phasedir_d = dir_d ^ DINV;
    end
  end

  // State and output registers
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q   <= WAIT_LOCK;
      sync_q    <= '0;
      lcnt_q    <= '0;
      locked_o  <= 1'b0;
      tmr_q     <= '0;
      rem_q     <= '0;
      sel_q     <= '0;
      dir_q     <= 1'b0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      lcnt_q    <= lcnt_d;
      locked_o  <= locked_d;
      tmr_q     <= tmr_d;
      rem_q     <= rem_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      for (int i = 0; i < 4; i++) pos_q[i] <= pos_d[i];
      ready_q   <= ready_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      phasesel  <= phasesel_d;
      phasedir  <= phasedir_d;
      phasestep <= phasestep_d;
    end
  end

endmodule
